// File: rtl/wishbone_pipelined_initiator.sv
// Wishbone B4 pipelined initiator: accepts commands, issues strobes, tracks
// outstanding requests, returns one response per termination, aborts on timeout.
module wishbone_pipelined_initiator #(
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int Granularity    = 8,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 255
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  CmdValid,
  output logic                                  CmdReady,
  input  logic                                  CmdWrite,
  input  logic [AddressWidth-1:0]               CmdAddr,
  input  logic [DataWidth-1:0]                  CmdData,
  input  logic [DataWidth/Granularity-1:0]      CmdSel,
  output logic                                  RspValid,
  output logic [DataWidth-1:0]                  RspData,
  output logic                                  RspError,
  output logic                                  RspRetry,
  output logic                                  CYC,
  output logic                                  STB,
  output logic                                  WE,
  output logic [AddressWidth-1:0]               ADDR,
  output logic [DataWidth/Granularity-1:0]      SEL,
  output logic [DataWidth-1:0]                  DAT_ToTarget,
  input  logic [DataWidth-1:0]                  DAT_ToInitiator,
  input  logic                                  ACK,
  input  logic                                  ERR,
  input  logic                                  RTY,
  input  logic                                  STALL
);

  localparam int SELWidth = DataWidth / Granularity;
  localparam int CntW     = $clog2(MaxOutstanding + 1);
  localparam int TmoW     = $clog2(TimeoutCycles + 1);
  localparam logic [CntW:0]   MaxOut  = (CntW+1)'(MaxOutstanding);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

  state_t          state;
  logic [CntW-1:0] outstanding;
  logic [TmoW-1:0] tmo;

  logic            issue;
  logic            term;
  logic            accept;
  logic            tmo_expire;
  logic            stb_next;
  logic [CntW:0]   load;
  logic [CntW-1:0] out_next;

  assign issue  = STB & ~STALL;
  assign term   = (state == ACTIVE) & CYC & (ACK | ERR | RTY) & (outstanding != '0);
  assign load   = {1'b0, outstanding} + (CntW+1)'(issue);

  // Expiry fires on the edge where the idle count would reach TimeoutCycles.
  assign tmo_expire = (state == ACTIVE) & ~term & (outstanding != '0) & (tmo == TmoLast);

  assign CmdReady = ~RST & (state != ABORT) & (~STB | ~STALL) & ~tmo_expire & (load < MaxOut);
  assign accept   = CmdValid & CmdReady;
  assign stb_next = accept | (STB & STALL);

  always_comb begin
    out_next = outstanding;
    case ({issue, term})
      2'b10:   out_next = outstanding + CntW'(1);
      2'b01:   out_next = outstanding - CntW'(1);
      default: out_next = outstanding;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      outstanding  <= '0;
      tmo          <= '0;
      CYC          <= 1'b0;
      STB          <= 1'b0;
      WE           <= 1'b0;
      ADDR         <= '0;
      SEL          <= '0;
      DAT_ToTarget <= '0;
      RspValid     <= 1'b0;
      RspData      <= '0;
      RspError     <= 1'b0;
      RspRetry     <= 1'b0;
    end else begin
      RspValid <= 1'b0;
      RspError <= 1'b0;
      RspRetry <= 1'b0;

      if (accept) begin
        ADDR         <= CmdAddr;
        WE           <= CmdWrite;
        DAT_ToTarget <= CmdData;
        SEL          <= CmdWrite ? CmdSel : {SELWidth{1'b1}};
      end

      case (state)
        IDLE: begin
          outstanding <= '0;
          tmo         <= '0;
          if (accept) begin
            state <= ACTIVE;
            CYC   <= 1'b1;
            STB   <= 1'b1;
          end
        end

        ACTIVE: begin
          if (term) begin
            RspValid <= 1'b1;
            RspData  <= DAT_ToInitiator;
            RspError <= ERR;
            RspRetry <= RTY & ~ERR;
          end
          if (tmo_expire) begin
            state       <= ABORT;
            CYC         <= 1'b0;
            STB         <= 1'b0;
            outstanding <= '0;
            tmo         <= '0;
            RspValid    <= 1'b1;
            RspError    <= 1'b1;
          end else begin
            outstanding <= out_next;
            STB         <= stb_next;
            tmo         <= (term || outstanding == '0) ? '0 : tmo + TmoW'(1);
            // Error and retry terminations never close the cycle early.
            if (out_next == '0 && !stb_next) begin
              state <= IDLE;
              CYC   <= 1'b0;
            end
          end
        end

        ABORT: begin
          state       <= IDLE;
          outstanding <= '0;
          tmo         <= '0;
          CYC         <= 1'b0;
          STB         <= 1'b0;
        end

        default: begin
          state <= IDLE;
          CYC   <= 1'b0;
          STB   <= 1'b0;
        end
      endcase
    end
  end

endmodule
